// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requesters A/B and register-file write port bundle
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              write_ce;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              starve_boost;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write_ce, write_addr, write_data, starve_boost
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write_ce, write_addr, write_data, starve_boost
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - fixed-priority writeback arbiter onto the register-file write port
// Optional starvation guard for the LSU requester: define WB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT =
        (STARVE_LIMIT < 1)  ? CNT_W'(1)  :
        (STARVE_LIMIT > 15) ? CNT_W'(15) : CNT_W'(STARVE_LIMIT);

    logic              boost;
    logic              grant_a;
    logic              grant_b;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

`ifdef WB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    // Counts contended cycles B has lost in a row; any B grant or B going idle restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.b_valid || grant_b) begin
            starve_cnt <= '0;
        end else if (bus.a_valid && grant_a && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign boost = (starve_cnt == LIMIT);
`else
    // LIMIT is clamped to at least 1, so B is never boosted in this build.
    assign boost = (LIMIT == '0);
`endif

    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        if (!rst) begin
            if (bus.a_valid && !(bus.b_valid && boost)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
        grant    = grant_a || grant_b;
        win_addr = grant_b ? bus.b_addr : bus.a_addr;
        win_data = grant_b ? bus.b_data : bus.a_data;
    end

    assign bus.a_ready      = grant_a;
    assign bus.b_ready      = grant_b;
    assign bus.starve_boost = boost;

    // Register-0 writes are still granted so the requester retires, but never reach the file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.write_ce   <= 1'b0;
            bus.write_addr <= '0;
            bus.write_data <= '0;
        end else begin
            bus.write_ce <= grant && (win_addr != '0);
            if (grant) begin
                bus.write_addr <= win_addr;
                bus.write_data <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: B's current losing streak, expected write-port contents, and both register files.
    int                lost;
    logic              exp_ce;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] mrf [32];
    logic [DATA_W-1:0] rf  [32];
    logic              a_fire, b_fire, obs_b_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        logic boost, ga, gb, any;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        @(negedge clk);
        if (rst) begin
            lost = 0; exp_ce = 1'b0; exp_addr = '0; exp_data = '0;
        end
        boost = GUARD && !rst && (lost >= STARVE_LIMIT);
        ga = !rst && bus.a_valid && !(bus.b_valid && boost);
        gb = !rst && bus.b_valid && !ga;
        chk("a_ready", bus.a_ready, ga);
        chk("b_ready", bus.b_ready, gb);
        chk("starve_boost", bus.starve_boost, boost);
        chk("write_ce", bus.write_ce, exp_ce);
        chk("write_addr", bus.write_addr, exp_addr);
        chk("write_data", bus.write_data, exp_data);
        obs_b_ready = bus.b_ready;
        if (bus.write_ce === 1'b1) rf[bus.write_addr] = bus.write_data;
        if (!rst) begin
            any   = ga || gb;
            waddr = gb ? bus.b_addr : bus.a_addr;
            wdata = gb ? bus.b_data : bus.a_data;
            exp_ce = any && (waddr != 0);
            if (any) begin exp_addr = waddr; exp_data = wdata; end
            if (exp_ce) mrf[waddr] = wdata;
            if (!bus.b_valid || gb) lost = 0;
            else if (bus.a_valid && ga) lost = (lost + 1 > STARVE_LIMIT) ? STARVE_LIMIT : lost + 1;
        end
        a_fire = ga;
        b_fire = gb;
        @(posedge clk);
        #1;
    endtask

    task automatic new_a(); bus.a_valid = 1'b1; bus.a_addr = ADDR_W'($urandom_range(0, 7)); bus.a_data = $urandom; endtask
    task automatic new_b(); bus.b_valid = 1'b1; bus.b_addr = ADDR_W'($urandom_range(0, 7)); bus.b_data = $urandom; endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mrf[i] = '0; rf[i] = '0; end
        lost = 0; exp_ce = 1'b0; exp_addr = '0; exp_data = '0;
        a_fire = 1'b0; b_fire = 1'b0; obs_b_ready = 1'b0;

        // Reset held with A requesting, then released.
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hAA;
        bus.b_valid = 1'b0; bus.b_addr = '0;   bus.b_data = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        bus.a_valid = 1'b0;
        chk("rst_release_ce", bus.write_ce, 1'b1);
        step();

        // Single A write, one cycle.
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
        step();
        bus.a_valid = 1'b0;
        chk("single_a_ce", bus.write_ce, 1'b1);
        chk("single_a_addr", bus.write_addr, 5'd5);
        chk("single_a_data", bus.write_data, 32'h1234);
        step();
        chk("single_a_ce_drop", bus.write_ce, 1'b0);

        // Register 0 write is accepted and dropped.
        bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFF_FFFF;
        step();
        bus.b_valid = 1'b0;
        chk("reg0_b_ready", obs_b_ready, 1'b1);
        chk("reg0_ce", bus.write_ce, 1'b0);
        step();

        // Continuous contention: B wins every (STARVE_LIMIT+1)-th cycle only with the guard.
        new_a(); new_b();
        bus.b_addr = 5'd9;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("contend_b_ready_%0d", i), obs_b_ready,
                GUARD ? ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT) : 1'b0);
            if (a_fire) new_a();
            if (b_fire) new_b();
        end
        bus.a_valid = 1'b0;
        step();
        chk("contend_drop_a_b_ready", obs_b_ready, 1'b1);
        bus.b_valid = 1'b0;
        step();

        // Same destination from both: A then B, B's value final.
        bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h22;
        step();
        bus.a_valid = 1'b0;
        chk("same_dst_first", bus.write_data, 32'h11);
        step();
        bus.b_valid = 1'b0;
        chk("same_dst_second", bus.write_data, 32'h22);
        step();
        chk("same_dst_reg7", rf[7], 32'h22);

        // Randomized traffic with occasional mid-operation reset.
        for (int c = 0; c < 400; c++) begin
            if (!bus.a_valid || a_fire) begin
                if ($urandom_range(0, 3) != 0) new_a(); else bus.a_valid = 1'b0;
            end
            if (!bus.b_valid || b_fire) begin
                if ($urandom_range(0, 3) != 0) new_b(); else bus.b_valid = 1'b0;
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 32; i++) chk($sformatf("final_rf_%0d", i), rf[i], mrf[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
